// File: rtl/commit_arbiter_unit.sv
// Round-robin commit arbiter: merges NUM_UNITS commit streams into one registered
// writeback/commit port, holding sop/eop bursts atomic. Counters gated by COMMIT_ARB_PERF_EN.
module commit_arbiter_unit #(
    parameter int NUM_UNITS   = 4,
    parameter int NUM_THREADS = 4,
    parameter int NW_WIDTH    = 2,
    parameter int XLEN        = 32,
    parameter int NR_BITS     = 6,
    parameter int UUID_WIDTH  = 1,
    parameter int CNT_WIDTH   = 32,
    parameter int DATAW       = UUID_WIDTH + NW_WIDTH + NUM_THREADS + XLEN + 1 + NR_BITS
                                + NUM_THREADS * XLEN + 1 + 1 + 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_UNITS-1:0]            in_valid,
    output logic [NUM_UNITS-1:0]            in_ready,
    input  logic [NUM_UNITS*DATAW-1:0]      in_data,
    output logic                            wb_valid,
    output logic [NW_WIDTH-1:0]             wb_wid,
    output logic [NR_BITS-1:0]              wb_rd,
    output logic [NUM_THREADS-1:0]          wb_tmask,
    output logic [NUM_THREADS*XLEN-1:0]     wb_data,
    output logic [XLEN-1:0]                 wb_pc,
    output logic                            sched_valid,
    output logic [NW_WIDTH-1:0]             sched_wid,
    output logic [CNT_WIDTH-1:0]            instr_count,
    output logic [CNT_WIDTH-1:0]            stall_count
);

    localparam int PTR_W     = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int EOP_B     = 0;
    localparam int SOP_B     = 1;
    localparam int PID_B     = 2;
    localparam int DATA_LSB  = 3;
    localparam int RD_LSB    = DATA_LSB + NUM_THREADS * XLEN;
    localparam int WB_B      = RD_LSB + NR_BITS;
    localparam int PC_LSB    = WB_B + 1;
    localparam int TMASK_LSB = PC_LSB + XLEN;
    localparam int WID_LSB   = TMASK_LSB + NUM_THREADS;
    localparam int UUID_LSB  = WID_LSB + NW_WIDTH;

    localparam logic [PTR_W:0]   NU_EXT = (PTR_W + 1)'(NUM_UNITS);
    localparam logic [PTR_W-1:0] LAST_U = PTR_W'(NUM_UNITS - 1);

    logic [PTR_W-1:0]             r_rr_ptr;
    logic                         r_lock;
    logic [PTR_W-1:0]             r_lock_unit;
    logic                         r_wb_valid;
    logic [NW_WIDTH-1:0]          r_wb_wid;
    logic [NR_BITS-1:0]           r_wb_rd;
    logic [NUM_THREADS-1:0]       r_wb_tmask;
    logic [NUM_THREADS*XLEN-1:0]  r_wb_data;
    logic [XLEN-1:0]              r_wb_pc;
    logic                         r_sched_valid;
    logic [NW_WIDTH-1:0]          r_sched_wid;

    logic [DATAW-1:0]             w_pkt [NUM_UNITS];
    logic [DATAW-1:0]             w_sel;
    logic                         w_found;
    logic [PTR_W-1:0]             w_gidx;
    logic [PTR_W:0]               w_scan;
    logic [NUM_UNITS-1:0]         w_ready;
    logic [PTR_W-1:0]             w_rr_next;
    logic                         w_accept;
    logic                         w_eop;
    logic                         w_wb;
    logic [NW_WIDTH-1:0]          w_wid;
    logic                         w_unused_fields;

    for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unpack
        assign w_pkt[u] = in_data[u*DATAW +: DATAW];
    end

    // Grant: the locked unit alone, otherwise first valid unit at or after rr_ptr.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_scan  = '0;
        if (r_lock) begin
            w_gidx  = r_lock_unit;
            w_found = in_valid[r_lock_unit];
        end else begin
            for (int i = NUM_UNITS - 1; i >= 0; i--) begin
                w_scan = {1'b0, r_rr_ptr} + (PTR_W + 1)'(i);
                if (w_scan >= NU_EXT) begin
                    w_scan = w_scan - NU_EXT;
                end
                if (in_valid[w_scan[PTR_W-1:0]]) begin
                    w_found = 1'b1;
                    w_gidx  = w_scan[PTR_W-1:0];
                end
            end
        end
    end

    always_comb begin
        w_ready = '0;
        if (w_found) begin
            w_ready[w_gidx] = 1'b1;
        end
    end

    assign in_ready  = w_ready;
    assign w_accept  = w_found;
    assign w_sel     = w_pkt[w_gidx];
    assign w_eop     = w_sel[EOP_B];
    assign w_wb      = w_sel[WB_B];
    assign w_wid     = w_sel[WID_LSB +: NW_WIDTH];
    assign w_rr_next = (w_gidx == LAST_U) ? '0 : w_gidx + 1'b1;

    // sop, pid and uuid ride along but do not steer arbitration.
    assign w_unused_fields = ^{w_sel[SOP_B], w_sel[PID_B], w_sel[UUID_LSB +: UUID_WIDTH]};

    // Arbitration state and registered commit port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr      <= '0;
            r_lock        <= 1'b0;
            r_lock_unit   <= '0;
            r_wb_valid    <= 1'b0;
            r_wb_wid      <= '0;
            r_wb_rd       <= '0;
            r_wb_tmask    <= '0;
            r_wb_data     <= '0;
            r_wb_pc       <= '0;
            r_sched_valid <= 1'b0;
            r_sched_wid   <= '0;
        end else begin
            r_wb_valid    <= w_accept && w_wb;
            r_sched_valid <= w_accept && w_eop;
            if (w_accept) begin
                r_wb_wid   <= w_wid;
                r_wb_rd    <= w_sel[RD_LSB +: NR_BITS];
                r_wb_tmask <= w_sel[TMASK_LSB +: NUM_THREADS];
                r_wb_data  <= w_sel[DATA_LSB +: NUM_THREADS*XLEN];
                r_wb_pc    <= w_sel[PC_LSB +: XLEN];
                if (w_eop) begin
                    r_lock      <= 1'b0;
                    r_rr_ptr    <= w_rr_next;
                    r_sched_wid <= w_wid;
                end else begin
                    r_lock      <= 1'b1;
                    r_lock_unit <= w_gidx;
                end
            end
        end
    end

    assign wb_valid    = r_wb_valid;
    assign wb_wid      = r_wb_wid;
    assign wb_rd       = r_wb_rd;
    assign wb_tmask    = r_wb_tmask;
    assign wb_data     = r_wb_data;
    assign wb_pc       = r_wb_pc;
    assign sched_valid = r_sched_valid;
    assign sched_wid   = r_sched_wid;

`ifdef COMMIT_ARB_PERF_EN
    logic [CNT_WIDTH-1:0] r_instr_count;
    logic [CNT_WIDTH-1:0] r_stall_count;
    logic                 w_stall;

    // A stall cycle is any cycle where some valid unit was refused.
    assign w_stall = |(in_valid & ~w_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr_count <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_accept && w_eop) begin
                r_instr_count <= r_instr_count + 1'b1;
            end
            if (w_stall) begin
                r_stall_count <= r_stall_count + 1'b1;
            end
        end
    end

    assign instr_count = r_instr_count;
    assign stall_count = r_stall_count;
`else
    assign instr_count = '0;
    assign stall_count = '0;
`endif

endmodule

// File: doc/commit_arbiter_unit.md
Name: commit_arbiter_unit

Overview:
- Downstream stage of the per-issue-slot commit gather.
- Per issue slot, one instance round-robin arbitrates NUM_UNITS execution-unit commit streams into a single registered writeback/commit port.
- Multi-packet instructions (sop/eop bursts) are kept atomic: once a unit wins, it keeps the port until its eop packet is accepted.
- Outputs drive the register-file write port and the scheduler's pending-instruction release.

Parameters:
- NUM_UNITS, 4: number of commit input streams (execution units).
- NUM_THREADS, 4: lanes per packet (full warp width after gather).
- NW_WIDTH, 2: warp id width.
- XLEN, 32: data word width.
- NR_BITS, 6: register index width.
- UUID_WIDTH, 1: instruction uuid width.
- CNT_WIDTH, 32: performance counter width.
- DATAW, derived: UUID_WIDTH+NW_WIDTH+NUM_THREADS+XLEN+1+NR_BITS+NUM_THREADS*XLEN+1+1+1.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  NUM_UNITS  per-unit commit valid.
- in_ready  out  NUM_UNITS  per-unit accept.
- in_data  in  NUM_UNITS*DATAW  per-unit packet; MSB-first fields {uuid, wid, tmask, PC, wb, rd, data, pid, sop, eop}.
- wb_valid  out  1  register-file write strobe.
- wb_wid  out  NW_WIDTH  write warp.
- wb_rd  out  NR_BITS  destination register.
- wb_tmask  out  NUM_THREADS  lane write enables.
- wb_data  out  NUM_THREADS*XLEN  write data.
- wb_pc  out  XLEN  PC of the committing instruction.
- sched_valid  out  1  instruction retired (eop accepted).
- sched_wid  out  NW_WIDTH  retired warp.
- instr_count  out  CNT_WIDTH  retired-instruction counter.
- stall_count  out  CNT_WIDTH  arbitration-loss cycle counter.

Behaviour:
- State: rr_ptr (clog2 NUM_UNITS bits), lock (1 bit), lock_unit (clog2 NUM_UNITS bits), output registers, counters.
- Async reset: rr_ptr=0, lock=0, lock_unit=0; all outputs 0.
- Output never back-pressures, so in_ready is combinational from in_valid and state, with no input-to-output cycle.
- Unlocked grant: first valid unit at or after rr_ptr, searching upward and wrapping modulo NUM_UNITS.
  - in_ready[g]=1 for the winner only; all others 0.
  - No valid input: no grant and no state change.
- Locked grant: only lock_unit is eligible.
  - in_ready[lock_unit]=in_valid[lock_unit]; all others 0.
  - If lock_unit drops valid mid-burst, the block stays locked and issues nothing.
- On accept with eop=0: lock<=1, lock_unit<=g; rr_ptr unchanged.
- On accept with eop=1: lock<=0, rr_ptr<=(g+1) mod NUM_UNITS.
- Packet sop is informational only.
  - sop=1 while locked from the same unit is treated as a continuation.
  - A single packet with sop=1 and eop=1 is a one-packet instruction.
- Latency: exactly 1 cycle from the accept edge to the registered outputs.
- wb_valid<=accept&&wb.
  - wb_wid, wb_rd, wb_tmask, wb_data and wb_pc load on every accept and hold when there is no accept.
  - A packet with wb=0 still commits but does not assert wb_valid.
- sched_valid<=accept&&eop; sched_wid<=wid of that packet.
- sched_valid and wb_valid are single-cycle pulses with no accept.
- NUM_UNITS=1: arbitration degenerates to in_ready=in_valid; the lock logic remains but is functionally irrelevant.
- Counters increment modulo 2^CNT_WIDTH and wrap silently.
  - instr_count +1 per accepted eop.
  - stall_count +1 per cycle in which any valid unit is not granted.

Optional Feature:
- Macro: COMMIT_ARB_PERF_EN.
- Defined: instr_count and stall_count are live as specified above.
- Undefined: both counters are tied to 0 and no counter flops are instantiated; ports remain for interface stability.

Test Plan:
- Reset mid-burst: assert reset while lock=1 on unit 2 -> lock=0, rr_ptr=0, all outputs 0 immediately. After release, unit 0 valid is granted first.
- Round-robin fairness: all 4 units valid with single-packet instructions (sop=eop=1) for 8 cycles -> grant order 0,1,2,3,0,1,2,3; sched_valid high each cycle one cycle later; instr_count=8 with COMMIT_ARB_PERF_EN.
- Burst atomicity: unit 1 sends 3 packets (sop, -, eop) while units 0 and 3 stay valid -> unit 1 holds the port 3 consecutive accepts; sched_valid only on the third; next grant goes to unit 3 (rr_ptr=2 wraps past empty unit 2).
- Locked bubble: unit 2 locked, deasserts valid for 2 cycles while unit 0 is valid -> no grant for 2 cycles; stall_count +2; unit 2's eop then unlocks.
- wb gating: unit 3 packet with wb=0, eop=1, wid=1 -> wb_valid=0, sched_valid=1, sched_wid=1.
- Counter wrap: CNT_WIDTH=4, 17 eop accepts -> instr_count=1. Macro undefined -> instr_count=0 and stall_count=0 throughout.
